sdr_frame_serializer: RTL and testbench

//  SDR-mode transmit serializer, directly downstream of the SCL generator.

---
 rtl/sdr_frame_serializer.sv | 124 ++++++++++++
 tb/tb_sdr_frame_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_frame_serializer.sv
// SDR transmit serializer: shifts a payload MSB-first onto SDA on SCL falling strobes,
// then optionally an ACK slot or an odd-parity T-bit, and reports completion/ACK status.
module sdr_frame_serializer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_sdr_ctrl_clk,
  input  logic              i_sdr_ctrl_rst,
  input  logic              i_ser_en,
  input  logic [DATA_W-1:0] i_ser_data,
  input  logic [1:0]        i_ser_mode,
  input  logic              i_scl_neg_edge,
  input  logic              i_scl_pos_edge,
  input  logic              i_sda,
  output logic              o_sda,
  output logic              o_ser_ready,
  output logic              o_ser_done,
  output logic              o_ack
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_NINTH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sda_q, sda_d;
  logic              ack_q, ack_d;

  always_ff @(posedge i_sdr_ctrl_clk) begin
    if (i_sdr_ctrl_rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      data_q    <= '0;
      mode_q    <= '0;
      bit_cnt_q <= '0;
      sda_q     <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      bit_cnt_q <= bit_cnt_d;
      sda_q     <= sda_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    mode_d    = mode_q;
    bit_cnt_d = bit_cnt_q;
    sda_d     = sda_q;
    ack_d     = ack_q;
    unique case (state_q)
      S_IDLE: begin
        sda_d = 1'b1;
        if (i_ser_en) begin
          shreg_d   = i_ser_data;
          data_d    = i_ser_data;
          mode_d    = i_ser_mode;
          bit_cnt_d = '0;
          ack_d     = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (i_scl_neg_edge) begin
          // The falling edge after the last payload bit ends that bit's SCL-high period.
          if (bit_cnt_q == CNT_W'(DATA_W)) begin
            unique case (mode_q)
              2'b00: begin
                sda_d   = 1'b1;
                state_d = S_NINTH;
              end
              2'b01: begin
                sda_d   = ~^data_q;
                state_d = S_NINTH;
              end
              default: begin
                sda_d   = 1'b1;
                state_d = S_DONE;
              end
            endcase
          end else begin
            sda_d     = shreg_q[DATA_W-1];
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_NINTH: begin
        if (i_scl_neg_edge) begin
          sda_d   = 1'b1;
          state_d = S_DONE;
        end else if (i_scl_pos_edge && (mode_q == 2'b00)) begin
          ack_d = ~i_sda;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_sda       = sda_q;
  assign o_ser_ready = (state_q == S_IDLE);
  assign o_ser_done  = (state_q == S_DONE);
  assign o_ack       = ack_q;

endmodule

// File: tb/tb_sdr_frame_serializer.sv
// Scoreboard bench for sdr_frame_serializer: a frame-level model builds the expected SDA
// sequence and ACK result; a monitor checks every launch and every done pulse.
module tb_sdr_frame_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] data = '0;
  logic [1:0] mode = '0;
  logic       neg = 1'b0;
  logic       pos = 1'b0;
  logic       sda_in = 1'b1;
  logic       o_sda, o_ready, o_done, o_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int   cyc;
    logic ack;
  } done_t;

  logic  exp_sda[$];
  done_t exp_done[$];

  sdr_frame_serializer #(.DATA_W(8)) dut (
    .i_sdr_ctrl_clk(clk),
    .i_sdr_ctrl_rst(rst),
    .i_ser_en(en),
    .i_ser_data(data),
    .i_ser_mode(mode),
    .i_scl_neg_edge(neg),
    .i_scl_pos_edge(pos),
    .i_sda(sda_in),
    .o_sda(o_sda),
    .o_ser_ready(o_ready),
    .o_ser_done(o_done),
    .o_ack(o_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) assert (!(neg && pos)) else $error("strobes overlap");

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares each launched bit and each done pulse against the scoreboard.
  initial begin
    logic  neg_s;
    logic  e;
    done_t d;
    forever begin
      @(posedge clk);
      neg_s = neg;
      #1;
      if (neg_s) begin
        checks++;
        if (exp_sda.size() == 0) begin
          errors++;
          $display("FAIL sda_launch: strobe with no expectation, sda=%0b", o_sda);
        end else begin
          e = exp_sda.pop_front();
          if (o_sda !== e) begin
            errors++;
            $display("FAIL sda_launch: got %0b expected %0b (t=%0t)", o_sda, e, $time);
          end
        end
      end
      if (o_done) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_pulse: unexpected done at cycle %0d", cyc);
        end else begin
          d = exp_done.pop_front();
          if (cyc != d.cyc || o_ack !== d.ack || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: cycle %0d ack %0b ready %0b expected cycle %0d ack %0b ready 0",
                     cyc, o_ack, o_ready, d.cyc, d.ack);
          end
        end
      end
    end
  end

  task automatic start(input logic [7:0] d, input logic [1:0] m);
    int n;
    data = d;
    mode = m;
    en   = 1'b1;
    n    = 0;
    while (!o_ready && n < 50) begin
      tick();
      n++;
    end
    check("start_ready", int'(o_ready), 1);
    tick();
    en = 1'b0;
    check("busy_after_start", int'(o_ready), 0);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [1:0] m, input logic drv_sda,
                           input int stall_at, input int en_at, input int abort_at,
                           output logic ack_out);
    logic  seq[$];
    logic  held;
    done_t dn;
    int    n;
    for (int i = 7; i >= 0; i--) seq.push_back(d[i]);
    if (m == 2'b00) seq.push_back(1'b1);
    else if (m == 2'b01) seq.push_back(($countones(d) % 2 == 0) ? 1'b1 : 1'b0);
    seq.push_back(1'b1);
    n       = seq.size();
    ack_out = (m == 2'b00) ? ~drv_sda : 1'b0;

    start(d, m);
    data = 8'($urandom);
    mode = 2'($urandom);

    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sda", int'(o_sda), 1);
        check("abort_ready", int'(o_ready), 1);
        check("abort_done", int'(o_done), 0);
        check("abort_ack", int'(o_ack), 0);
        ack_out = 1'b0;
        return;
      end
      if (k == stall_at) begin
        held = 1'b1;
        for (int s = 0; s < 200; s++) begin
          tick();
          if (o_sda !== seq[k-1] || o_ready !== 1'b0 || o_done !== 1'b0) held = 1'b0;
        end
        check("stall_hold", int'(held), 1);
      end
      if (k == en_at) begin
        en = 1'b1;
        tick();
        en = 1'b0;
        check("busy_en_ignored", int'(o_ready), 0);
      end
      neg = 1'b1;
      exp_sda.push_back(seq[k]);
      if (k == n - 1) begin
        dn.cyc = cyc + 1;
        dn.ack = ack_out;
        exp_done.push_back(dn);
      end
      tick();
      neg = 1'b0;
      if (k < n - 1) begin
        repeat ($urandom_range(0, 2)) tick();
        pos    = 1'b1;
        sda_in = (k == n - 2 && m == 2'b00) ? drv_sda : 1'($urandom);
        tick();
        pos    = 1'b0;
        sda_in = 1'b1;
        repeat ($urandom_range(0, 2)) tick();
      end
    end
  endtask

  task automatic idle_strobes();
    neg = 1'b1;
    exp_sda.push_back(1'b1);
    tick();
    neg    = 1'b0;
    pos    = 1'b1;
    sda_in = 1'b1;
    tick();
    pos = 1'b0;
    tick();
  endtask

  initial begin
    logic a;
    repeat (3) tick();
    check("rst_sda", int'(o_sda), 1);
    check("rst_ready", int'(o_ready), 1);
    check("rst_done", int'(o_done), 0);
    check("rst_ack", int'(o_ack), 0);
    rst = 1'b0;
    tick();

    idle_strobes();
    check("idle_ready", int'(o_ready), 1);

    run_frame(8'hA5, 2'b10, 1'b1, -1, -1, -1, a);
    run_frame(8'h03, 2'b01, 1'b0, -1, -1, -1, a);
    run_frame(8'h7E, 2'b00, 1'b0, -1, -1, -1, a);
    tick();
    tick();
    idle_strobes();
    check("ack_hold_idle", int'(o_ack), 1);
    run_frame(8'h7E, 2'b00, 1'b1, -1, -1, -1, a);
    check("ack_nack", int'(o_ack), 0);
    run_frame(8'h5A, 2'b11, 1'b0, -1, -1, -1, a);
    run_frame(8'hC3, 2'b01, 1'b0, -1, 4, -1, a);
    run_frame(8'hB7, 2'b01, 1'b0, -1, -1, 5, a);
    run_frame(8'h80, 2'b01, 1'b0, -1, -1, -1, a);
    run_frame(8'h96, 2'b00, 1'b0, 3, -1, -1, a);

    for (int f = 0; f < 30; f++) begin
      run_frame(8'($urandom), 2'($urandom), 1'($urandom), -1, -1, -1, a);
    end

    repeat (5) tick();
    check("sda_queue_drained", exp_sda.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
